// File: rtl/pmem_rr_scheduler.sv
// -----------------------------------------------------------------------------
// pmem_rr_scheduler
//   Shares one L2 line port between the icache miss path (port A) and the
//   dcache miss / write-back path (port B). The arbiter is round-robin. A grant
//   is held for the whole transaction. Every transaction is followed by one
//   IDLE cycle, so a requester that has just been served can drop its request
//   before arbitration runs again.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   read_x, write_x             level requests from port x (x = a, b), held
//                               until resp_x
//   address_x, wdata_x          line address and write line from port x
//   resp_x, rdata_x             transaction done and read line back to port x
//   mem_read, mem_write         registered command to L2
//   mem_address, mem_wdata      registered address and write line to L2
//   mem_resp, mem_rdata         L2 done and read line
//   clr_counts                  synchronous clear of both grant counters
//   grant_count_a/b             completed transactions per port, saturating
// -----------------------------------------------------------------------------
module pmem_rr_scheduler #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_a,
   input  logic              write_a,
   input  logic [ADDR_W-1:0] address_a,
   input  logic [LINE_W-1:0] wdata_a,
   output logic              resp_a,
   output logic [LINE_W-1:0] rdata_a,
   input  logic              read_b,
   input  logic              write_b,
   input  logic [ADDR_W-1:0] address_b,
   input  logic [LINE_W-1:0] wdata_b,
   output logic              resp_b,
   output logic [LINE_W-1:0] rdata_b,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              clr_counts,
   output logic [CNT_W-1:0]  grant_count_a,
   output logic [CNT_W-1:0]  grant_count_b
);

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } req_t;

   state_t state;
   logic   last_b;            // 1: port B held the most recent grant
   req_t   req_a_s, req_b_s, win;
   logic   req_a_any, req_b_any;
   logic   grant_a, grant_b;
   logic   done_a, done_b;

   assign req_a_s   = '{rd: read_a, wr: write_a, addr: address_a, wdata: wdata_a};
   assign req_b_s   = '{rd: read_b, wr: write_b, addr: address_b, wdata: wdata_b};
   assign req_a_any = read_a | write_a;
   assign req_b_any = read_b | write_b;

   // Arbitration only looks at requests while IDLE. On a tie the port that
   // did not win last time takes the grant, so continuous requesters alternate.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE) begin
         if (req_a_any && (!req_b_any || last_b))
            grant_a = 1'b1;
         else if (req_b_any)
            grant_b = 1'b1;
      end
   end

   assign win = grant_b ? req_b_s : req_a_s;

   // The response is steered only to the port that owns the grant. Read data
   // goes to both ports unqualified; resp marks the valid beat.
   assign done_a  = (state == SERVE_A) && mem_resp;
   assign done_b  = (state == SERVE_B) && mem_resp;
   assign resp_a  = done_a;
   assign resp_b  = done_b;
   assign rdata_a = mem_rdata;
   assign rdata_b = mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_b      <= 1'b1;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  mem_address <= win.addr;
                  mem_wdata   <= win.wdata;
                  // If a port raises read and write together, the write is issued.
                  mem_write   <= win.wr;
                  mem_read    <= win.rd & ~win.wr;
                  last_b      <= grant_b;
                  state       <= grant_b ? SERVE_B : SERVE_A;
               end
            end
            SERVE_A, SERVE_B: begin
               // Address and write data are left as they are, only the command drops.
               if (mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear wins over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count_a <= '0;
         grant_count_b <= '0;
      end else if (clr_counts) begin
         grant_count_a <= '0;
         grant_count_b <= '0;
      end else begin
         if (done_a && !(&grant_count_a))
            grant_count_a <= grant_count_a + CNT_W'(1);
         if (done_b && !(&grant_count_b))
            grant_count_b <= grant_count_b + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pmem_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pmem_rr_scheduler
//   Requester queues for both ports and a latency-programmable L2 responder
//   drive the scheduler. A cycle-level reference model predicts the grant
//   winner, the command on the L2 port, response steering and the grant
//   counters. A second instance with a 3-bit counter reaches saturation after
//   a few transactions.
// -----------------------------------------------------------------------------
module tb_pmem_rr_scheduler;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int CNT_W  = 16;
   localparam int SCW    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
   logic [ADDR_W-1:0] address_a = '0, address_b = '0;
   logic [LINE_W-1:0] wdata_a = '0, wdata_b = '0;
   logic              resp_a, resp_b;
   logic [LINE_W-1:0] rdata_a, rdata_b;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_resp = 1'b0;
   logic [LINE_W-1:0] mem_rdata = '0;
   logic              clr_counts = 1'b0;
   logic [CNT_W-1:0]  grant_count_a, grant_count_b;

   logic              s_resp_a, s_resp_b, s_mem_read, s_mem_write;
   logic [LINE_W-1:0] s_rdata_a, s_rdata_b, s_mem_wdata;
   logic [ADDR_W-1:0] s_mem_address;
   logic [SCW-1:0]    s_cnt_a, s_cnt_b;

   pmem_rr_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_a(read_a), .write_a(write_a), .address_a(address_a), .wdata_a(wdata_a),
      .resp_a(resp_a), .rdata_a(rdata_a),
      .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
      .resp_b(resp_b), .rdata_b(rdata_b),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .clr_counts(clr_counts), .grant_count_a(grant_count_a), .grant_count_b(grant_count_b)
   );

   pmem_rr_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(SCW)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .read_a(read_a), .write_a(write_a), .address_a(address_a), .wdata_a(wdata_a),
      .resp_a(s_resp_a), .rdata_a(s_rdata_a),
      .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
      .resp_b(s_resp_b), .rdata_b(s_rdata_b),
      .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_address(s_mem_address),
      .mem_wdata(s_mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .clr_counts(clr_counts), .grant_count_a(s_cnt_a), .grant_count_b(s_cnt_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                rd;
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } txn_t;

   int n_tests = 0;
   int n_fail  = 0;

   // requester side
   txn_t q_a[$], q_b[$];
   bit   pop_a, pop_b;
   int   gap_a, gap_b, gap_max;
   int   first_req_a;
   int   n_resp_a, n_resp_b;
   // responder / knobs
   int   lat_min, lat_max, wait_cnt, stale_pct, clr_pct;
   bit   garble, clr_on_resp;
   // reference model: owner 0 none, 1 A, 2 B
   int                owner, last;
   bit                cur_rd, cur_wr;
   logic [ADDR_W-1:0] hold_addr;
   logic [LINE_W-1:0] hold_wdata;
   int                m_cnt_a, m_cnt_b, ms_cnt_a, ms_cnt_b;
   int                glog[$], gcyc[$], ecyc[$];
   int                cyc = 0;

   function automatic logic [LINE_W-1:0] rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // kind 0 read, 1 write, 2 read+write asserted together
   function automatic txn_t mk_txn(input int kind, input logic [ADDR_W-1:0] addr);
      txn_t t;
      t.rd   = (kind != 1);
      t.wr   = (kind != 0);
      t.addr = addr;
      t.data = rnd_line();
      return t;
   endfunction

   function automatic string log_str();
      string s = "";
      foreach (glog[i]) s = {s, (glog[i] == 1) ? "A" : "B"};
      return s;
   endfunction

   task automatic model_clear();
      q_a.delete(); q_b.delete(); glog.delete(); gcyc.delete(); ecyc.delete();
      pop_a = 0; pop_b = 0; gap_a = 0; gap_b = 0; gap_max = 0;
      first_req_a = -1; n_resp_a = 0; n_resp_b = 0;
      lat_min = 1; lat_max = 1; wait_cnt = 0; stale_pct = 0; clr_pct = 0;
      garble = 0; clr_on_resp = 0;
      owner = 0; last = 2; cur_rd = 0; cur_wr = 0;
      hold_addr = '0; hold_wdata = '0;
      m_cnt_a = 0; m_cnt_b = 0; ms_cnt_a = 0; ms_cnt_b = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      read_a = 0; write_a = 0; read_b = 0; write_b = 0;
      mem_resp = 0; clr_counts = 0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive requesters and responder at negedge, check at +1,
   // then advance the model to what the next rising edge should produce.
   task automatic run_cycle();
      bit   act_a, act_b, mr, clr, exp_ra, exp_rb;
      int   win;
      txn_t h;
      @(negedge clk);
      cyc++;
      if (pop_a) begin void'(q_a.pop_front()); pop_a = 0; gap_a = $urandom_range(0, gap_max); end
      if (pop_b) begin void'(q_b.pop_front()); pop_b = 0; gap_b = $urandom_range(0, gap_max); end
      act_a = (q_a.size() != 0) && (gap_a == 0);
      act_b = (q_b.size() != 0) && (gap_b == 0);
      if (gap_a > 0) gap_a--;
      if (gap_b > 0) gap_b--;
      if (act_a && first_req_a < 0) first_req_a = cyc;

      if (act_a) begin
         h = q_a[0];
         read_a = h.rd; write_a = h.wr; address_a = h.addr; wdata_a = h.data;
         if (garble && owner == 1) begin address_a = ADDR_W'($urandom()); wdata_a = rnd_line(); end
      end else begin
         read_a = 0; write_a = 0; address_a = ADDR_W'($urandom()); wdata_a = rnd_line();
      end
      if (act_b) begin
         h = q_b[0];
         read_b = h.rd; write_b = h.wr; address_b = h.addr; wdata_b = h.data;
         if (garble && owner == 2) begin address_b = ADDR_W'($urandom()); wdata_b = rnd_line(); end
      end else begin
         read_b = 0; write_b = 0; address_b = ADDR_W'($urandom()); wdata_b = rnd_line();
      end

      mr = 0;
      if (owner != 0) begin
         if (wait_cnt == 0) mr = 1; else wait_cnt--;
      end else if (stale_pct != 0 && int'($urandom_range(0, 99)) < stale_pct) begin
         mr = 1;
      end
      clr = (clr_pct != 0 && int'($urandom_range(0, 99)) < clr_pct) ||
            (clr_on_resp && mr && owner != 0);
      mem_resp = mr; mem_rdata = rnd_line(); clr_counts = clr;
      #1;

      exp_ra = (owner == 1) && mr;
      exp_rb = (owner == 2) && mr;
      if (resp_a === 1'b1) n_resp_a++;
      if (resp_b === 1'b1) n_resp_b++;
      n_tests++;
      if (resp_a !== exp_ra) begin
         n_fail++; $display("FAIL resp_a cyc %0d: got %b want %b", cyc, resp_a, exp_ra);
      end
      n_tests++;
      if (resp_b !== exp_rb) begin
         n_fail++; $display("FAIL resp_b cyc %0d: got %b want %b", cyc, resp_b, exp_rb);
      end
      n_tests++;
      if (rdata_a !== mem_rdata || rdata_b !== mem_rdata) begin
         n_fail++; $display("FAIL rdata cyc %0d: got %h/%h want %h", cyc, rdata_a, rdata_b, mem_rdata);
      end
      n_tests++;
      if ({mem_read, mem_write} !== {cur_rd, cur_wr}) begin
         n_fail++; $display("FAIL mem_cmd cyc %0d: got rd=%b wr=%b want rd=%b wr=%b",
                            cyc, mem_read, mem_write, cur_rd, cur_wr);
      end
      n_tests++;
      if (mem_address !== hold_addr || mem_wdata !== hold_wdata) begin
         n_fail++; $display("FAIL mem_addr_data cyc %0d: got %h/%h want %h/%h",
                            cyc, mem_address, mem_wdata, hold_addr, hold_wdata);
      end
      n_tests++;
      if (grant_count_a !== CNT_W'(m_cnt_a) || grant_count_b !== CNT_W'(m_cnt_b)) begin
         n_fail++; $display("FAIL counts cyc %0d: got %0d/%0d want %0d/%0d",
                            cyc, grant_count_a, grant_count_b, m_cnt_a, m_cnt_b);
      end
      n_tests++;
      if ({s_resp_a, s_resp_b, s_mem_read, s_mem_write} !== {exp_ra, exp_rb, cur_rd, cur_wr} ||
          s_mem_address !== hold_addr || s_mem_wdata !== hold_wdata ||
          s_rdata_a !== mem_rdata || s_rdata_b !== mem_rdata ||
          s_cnt_a !== SCW'(ms_cnt_a) || s_cnt_b !== SCW'(ms_cnt_b)) begin
         n_fail++; $display("FAIL narrow_inst cyc %0d: cnt got %0d/%0d want %0d/%0d cmd got %b%b",
                            cyc, s_cnt_a, s_cnt_b, ms_cnt_a, ms_cnt_b, s_mem_read, s_mem_write);
      end

      if (owner == 0) begin
         win = 0;
         if (act_a && act_b) win = (last == 1) ? 2 : 1;
         else if (act_a)     win = 1;
         else if (act_b)     win = 2;
         if (win != 0) begin
            if (win == 1) h = q_a[0]; else h = q_b[0];
            cur_wr = h.wr; cur_rd = h.rd & ~h.wr;
            hold_addr = h.addr; hold_wdata = h.data;
            owner = win; last = win;
            wait_cnt = $urandom_range(lat_min, lat_max);
            glog.push_back(win); gcyc.push_back(cyc + 1);
         end
      end else if (mr) begin
         if (owner == 1) pop_a = 1; else pop_b = 1;
         if (!clr) begin
            if (owner == 1) begin
               if (m_cnt_a < 65535) m_cnt_a++;
               if (ms_cnt_a < 7) ms_cnt_a++;
            end else begin
               if (m_cnt_b < 65535) m_cnt_b++;
               if (ms_cnt_b < 7) ms_cnt_b++;
            end
         end
         ecyc.push_back(cyc);
         owner = 0; cur_rd = 0; cur_wr = 0;
      end
      if (clr) begin m_cnt_a = 0; m_cnt_b = 0; ms_cnt_a = 0; ms_cnt_b = 0; end
   endtask

   task automatic run_until_empty(input int budget, input string tag);
      int n = 0;
      do begin
         run_cycle();
         n++;
      end while ((q_a.size() != 0 || q_b.size() != 0 || owner != 0) && n < budget);
      n_tests++;
      if (q_a.size() != 0 || q_b.size() != 0 || owner != 0) begin
         n_fail++; $display("FAIL %s timeout: %0d/%0d txns left after %0d cycles",
                            tag, q_a.size(), q_b.size(), n);
      end
   endtask

   // every grant after the first follows the previous completion by 2 cycles
   task automatic check_gaps(input string tag);
      for (int i = 0; i + 1 < gcyc.size() && i < ecyc.size(); i++) begin
         n_tests++;
         if (gcyc[i+1] - ecyc[i] != 2) begin
            n_fail++; $display("FAIL %s gap %0d: got %0d cycles want 2", tag, i, gcyc[i+1] - ecyc[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0; read_a = 1; write_b = 1; mem_resp = 1;
      address_a = 16'h1234; address_b = 16'h4321;
      @(negedge clk); @(negedge clk); #1;
      n_tests++;
      if ({mem_read, mem_write, resp_a, resp_b} !== 4'b0000 || mem_address !== '0 ||
          mem_wdata !== '0 || grant_count_a !== '0 || grant_count_b !== '0) begin
         n_fail++; $display("FAIL reset_state: got rd=%b wr=%b ra=%b rb=%b addr=%h cnt=%0d/%0d want all 0",
                            mem_read, mem_write, resp_a, resp_b, mem_address, grant_count_a, grant_count_b);
      end
      do_reset();
      stale_pct = 100;   // mem_resp while idle must be ignored
      for (int i = 0; i < 3; i++) run_cycle();
   endtask

   task automatic test_single_read();
      do_reset();
      lat_min = 3; lat_max = 3;
      q_a.push_back(mk_txn(0, 16'h0123));
      run_until_empty(40, "single_read");
      n_tests++;
      if (log_str() != "A") begin n_fail++; $display("FAIL single_order: got %s want A", log_str()); end
      n_tests++;
      if (gcyc.size() != 1 || gcyc[0] - first_req_a != 1) begin
         n_fail++; $display("FAIL single_latency: got %0d want 1", (gcyc.size() != 0) ? gcyc[0] - first_req_a : -1);
      end
      n_tests++;
      if (n_resp_a != 1 || n_resp_b != 0) begin
         n_fail++; $display("FAIL single_resp_pulses: got %0d/%0d want 1/0", n_resp_a, n_resp_b);
      end
      n_tests++;
      if (grant_count_a !== 16'd1 || mem_address !== 16'h0123) begin
         n_fail++; $display("FAIL single_final: got cnt %0d addr %h want 1 0123", grant_count_a, mem_address);
      end
   endtask

   task automatic test_tie();
      do_reset();
      q_a.push_back(mk_txn(0, 16'h0a00));
      q_b.push_back(mk_txn(1, 16'h0b00));
      run_until_empty(40, "tie");
      n_tests++;
      if (log_str() != "AB") begin n_fail++; $display("FAIL tie_order: got %s want AB", log_str()); end
      n_tests++;
      if (grant_count_a !== 16'd1 || grant_count_b !== 16'd1) begin
         n_fail++; $display("FAIL tie_counts: got %0d/%0d want 1/1", grant_count_a, grant_count_b);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      lat_min = 0; lat_max = 2;
      for (int i = 0; i < 3; i++) begin
         q_a.push_back(mk_txn($urandom_range(0, 2), ADDR_W'($urandom())));
         q_b.push_back(mk_txn($urandom_range(0, 2), ADDR_W'($urandom())));
      end
      run_until_empty(100, "alternate");
      n_tests++;
      if (log_str() != "ABABAB") begin n_fail++; $display("FAIL alt_order: got %s want ABABAB", log_str()); end
      check_gaps("alt");
      n_tests++;
      if (grant_count_a !== 16'd3 || grant_count_b !== 16'd3) begin
         n_fail++; $display("FAIL alt_counts: got %0d/%0d want 3/3", grant_count_a, grant_count_b);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      q_b.push_back(mk_txn(1, 16'h0b10));
      q_b.push_back(mk_txn(0, 16'h0b20));
      run_until_empty(40, "b2b_same");
      n_tests++;
      if (log_str() != "BB") begin n_fail++; $display("FAIL b2b_order: got %s want BB", log_str()); end
      check_gaps("b2b");
      // A raises its request while B's write-back is in flight
      do_reset();
      lat_min = 3; lat_max = 3;
      q_b.push_back(mk_txn(1, 16'h0b30));
      q_b.push_back(mk_txn(0, 16'h0b40));
      q_a.push_back(mk_txn(0, 16'h0a30));
      gap_a = 2;
      run_until_empty(60, "b2b_cut_in");
      n_tests++;
      if (log_str() != "BAB") begin n_fail++; $display("FAIL b2b_cut_in_order: got %s want BAB", log_str()); end
      check_gaps("b2b_cut_in");
   endtask

   task automatic test_reset_mid();
      do_reset();
      q_a.push_back(mk_txn(0, 16'h0a55));
      run_until_empty(40, "mid_a");
      lat_min = 30; lat_max = 30;
      q_b.push_back(mk_txn(0, 16'h0b55));
      for (int i = 0; i < 4; i++) run_cycle();
      n_tests++;
      if (mem_read !== 1'b1 || grant_count_a !== 16'd1) begin
         n_fail++; $display("FAIL mid_setup: got rd=%b cnt=%0d want 1 1", mem_read, grant_count_a);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({mem_read, mem_write, resp_b} !== 3'b000 || mem_address !== '0 ||
          grant_count_a !== '0 || grant_count_b !== '0) begin
         n_fail++; $display("FAIL mid_reset_async: got rd=%b wr=%b rb=%b addr=%h cnt=%0d want 0",
                            mem_read, mem_write, resp_b, mem_address, grant_count_a);
      end
      @(negedge clk);
      read_b = 0; write_b = 0; rst_n = 1'b1; mem_resp = 1'b1;
      #1;
      n_tests++;
      if (resp_b !== 1'b0 || resp_a !== 1'b0) begin
         n_fail++; $display("FAIL mid_stale_resp: got %b/%b want 0/0", resp_a, resp_b);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      n_tests++;
      if ({mem_read, mem_write} !== 2'b00 || grant_count_a !== '0 || grant_count_b !== '0) begin
         n_fail++; $display("FAIL mid_after: got rd=%b wr=%b cnt=%0d/%0d want 0", mem_read, mem_write,
                            grant_count_a, grant_count_b);
      end
      model_clear();
   endtask

   task automatic test_saturate();
      do_reset();
      lat_min = 0; lat_max = 1;
      for (int i = 0; i < 6; i++) q_a.push_back(mk_txn(0, ADDR_W'(i)));
      run_until_empty(100, "sat_fill");
      n_tests++;
      if (s_cnt_a !== 3'd6 || grant_count_a !== 16'd6) begin
         n_fail++; $display("FAIL sat_pre: got %0d/%0d want 6/6", s_cnt_a, grant_count_a);
      end
      for (int i = 0; i < 3; i++) q_a.push_back(mk_txn(1, ADDR_W'(i + 8)));
      run_until_empty(100, "sat_over");
      n_tests++;
      if (s_cnt_a !== 3'd7 || grant_count_a !== 16'd9) begin
         n_fail++; $display("FAIL sat_hold: got %0d/%0d want 7/9", s_cnt_a, grant_count_a);
      end
      clr_on_resp = 1;
      q_a.push_back(mk_txn(0, 16'h0fff));
      run_until_empty(40, "sat_clr");
      n_tests++;
      if (s_cnt_a !== 3'd0 || grant_count_a !== 16'd0) begin
         n_fail++; $display("FAIL sat_clr_priority: got %0d/%0d want 0/0", s_cnt_a, grant_count_a);
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 0; lat_max = 4; gap_max = 3;
      stale_pct = 10; clr_pct = 3; garble = 1;
      gap_a = $urandom_range(0, 3); gap_b = $urandom_range(0, 3);
      for (int i = 0; i < 40; i++) begin
         q_a.push_back(mk_txn($urandom_range(0, 2), ADDR_W'($urandom())));
         q_b.push_back(mk_txn($urandom_range(0, 2), ADDR_W'($urandom())));
      end
      run_until_empty(4000, "random");
      n_tests++;
      if (glog.size() != 80) begin
         n_fail++; $display("FAIL random_grants: got %0d want 80", glog.size());
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_read();
      test_tie();
      test_alternate();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
